// File: rtl/decomp_backend_tx.sv
// Packet BRAM to AXI-Stream drain stage with a prefetch FIFO and read-latency credit.
// Optional counters enabled by DECOMP_BACKEND_TX_STATS_EN.
module decomp_backend_tx #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 6,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [15:0]           length_be,
  output logic                  finish,
  output logic [ADDR_W-1:0]     bram_addrb,
  output logic                  bram_enb,
  input  logic [DATA_W-1:0]     bram_doutb,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
`ifdef DECOMP_BACKEND_TX_STATS_EN
  ,
  output logic [31:0]           stat_pkts,
  output logic [31:0]           stat_stall
`endif
);

  localparam int KW  = DATA_W / 8;
  localparam int OW  = $clog2(KW);
  localparam int BW  = ADDR_W + 1;
  localparam int LW  = ADDR_W + OW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CAP = (1 << ADDR_W) * KW;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [LW-1:0]     len_c;
  logic [LW-1:0]     len_sum;
  logic [BW-1:0]     beats_c;
  logic [KW-1:0]     keep_c;
  logic [BW-1:0]     beats_q;
  logic [KW-1:0]     last_keep;
  logic [BW-1:0]     rd_ptr;
  logic [BW-1:0]     wr_cnt;
  logic [RD_LAT-1:0] vld_sr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     inflight;
  logic [CW:0]       occ;
  logic [PW-1:0]     wr_p;
  logic [PW-1:0]     rd_p;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic ret_vld, empty, issue, hs, push, pop, is_last;

  always_comb begin
    if (length_be > 16'(CAP)) len_c = LW'(CAP);
    else len_c = length_be[LW-1:0];
    len_sum = len_c + LW'(KW - 1);
    beats_c = len_sum[LW-1:OW];
    if (len_c[OW-1:0] == '0) keep_c = '1;
    else keep_c = (KW'(1) << len_c[OW-1:0]) - KW'(1);
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + CW'(vld_sr[i]);
  end

  // Reads are only issued when every outstanding read has a FIFO slot.
  assign occ     = (CW+1)'(cnt) + (CW+1)'(inflight);
  assign ret_vld = vld_sr[RD_LAT-1];
  assign empty   = (cnt == '0);
  assign issue   = (state == STREAM) && (rd_ptr < beats_q)
                && (occ < (CW+1)'(FIFO_DEPTH));
  assign is_last = (wr_cnt == beats_q - BW'(1));

  assign m_axis_tvalid = ret_vld || !empty;
  assign hs            = m_axis_tvalid && m_axis_tready;
  // Returning data bypasses an empty FIFO; it is kept only if not taken now.
  assign push          = ret_vld && !(empty && m_axis_tready);
  assign pop           = hs && !empty;

  always_comb begin
    m_axis_tdata = '0;
    if (!empty) m_axis_tdata = mem[rd_p];
    else if (ret_vld) m_axis_tdata = bram_doutb;
  end

  assign m_axis_tkeep = !m_axis_tvalid ? '0 : (is_last ? last_keep : '1);
  assign m_axis_tlast = m_axis_tvalid && is_last;
  assign bram_enb     = issue;
  assign bram_addrb   = rd_ptr[ADDR_W-1:0];
  assign finish       = (state == DONE);

  // Zero-length packets pass through LOAD so finish lands two cycles after start.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (len_c == '0) ? LOAD : STREAM;
      LOAD:    state_nx = DONE;
      STREAM:  if (hs && is_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      beats_q   <= '0;
      last_keep <= '0;
      rd_ptr    <= '0;
      wr_cnt    <= '0;
      vld_sr    <= '0;
      cnt       <= '0;
      wr_p      <= '0;
      rd_p      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        beats_q   <= beats_c;
        last_keep <= keep_c;
        rd_ptr    <= '0;
        wr_cnt    <= '0;
      end else begin
        if (issue) rd_ptr <= rd_ptr + BW'(1);
        if (hs) wr_cnt <= wr_cnt + BW'(1);
      end
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++)
        vld_sr[i] <= vld_sr[i-1];
      cnt <= cnt + CW'(push) - CW'(pop);
      if (push) wr_p <= wr_p + PW'(1);
      if (pop) rd_p <= rd_p + PW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_p] <= bram_doutb;
  end

`ifdef DECOMP_BACKEND_TX_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_pkts  <= '0;
      stat_stall <= '0;
    end else begin
      if (finish && stat_pkts != '1)
        stat_pkts <= stat_pkts + 32'd1;
      if (m_axis_tvalid && !m_axis_tready && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
